// File: rtl/bit_addr_lut_pkg.sv
// Shared types and constants for the bit-address lookup table.
// The default table holds bit addresses of the form byte*8 + bit, where bit 7
// of a byte is numbered 0.
package bit_addr_lut_pkg;

  localparam int KEY_W  = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 9;

  typedef logic [ADDR_W-1:0] bit_addr_t;

  // Power-on contents of the table; the last entry is a spare slot left at 0.
  localparam bit_addr_t DEFAULT_TABLE [DEPTH] = '{
    9'd0,   9'd1,   9'd5,   9'd8,
    9'd240, 9'd247, 9'd248, 9'd251,
    9'd253, 9'd254, 9'd255, 9'd256,
    9'd264, 9'd272, 9'd280, 9'd0
  };

  // Per-channel cursor state: IDLE until the first lookup loads a cursor.
  typedef enum logic {
    IDLE   = 1'b0,
    LOADED = 1'b1
  } ch_state_t;

  // Default value for any table index; indices beyond the default list read 0,
  // so a top level built with a larger DEPTH gets zeros in the extra slots.
  function automatic bit_addr_t default_entry(input int idx);
    bit_addr_t v;
    v = '0;
    if (idx >= 0 && idx < DEPTH) begin
      v = DEFAULT_TABLE[idx[$clog2(DEPTH)-1:0]];
    end
    return v;
  endfunction

endpackage

// File: rtl/bit_addr_cursor.sv
// One read channel: holds the IDLE/LOADED state, the bit-address cursor and
// the one-cycle valid/err/wrap pulses. The looked-up table value and the
// out-of-range flag come in from the top level already resolved.
module bit_addr_cursor #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              step,
  input  logic              key_err,
  input  logic [ADDR_W-1:0] lookup_val,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              err,
  output logic              wrap
);
  import bit_addr_lut_pkg::*;

  ch_state_t         state_reg;
  logic [ADDR_W-1:0] cursor_reg;
  logic              valid_reg;
  logic              err_reg;
  logic              wrap_reg;

  // Channel FSM: a request always reloads the cursor (and beats a step in the
  // same cycle); a step only advances a cursor that has been loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cursor_reg <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
      if (req) begin
        state_reg <= LOADED;
        valid_reg <= 1'b1;
        if (key_err) begin
          cursor_reg <= '0;
          err_reg    <= 1'b1;
        end else begin
          cursor_reg <= lookup_val;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            // A step without a loaded cursor has nothing to advance.
          end
          LOADED: begin
            if (step) begin
              cursor_reg <= cursor_reg + 1'b1;
              valid_reg  <= 1'b1;
              wrap_reg   <= &cursor_reg;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign addr  = cursor_reg;
  assign valid = valid_reg;
  assign err   = err_reg;
  assign wrap  = wrap_reg;

endmodule

// File: rtl/bit_addr_lut.sv
// Run-time-programmable bit-address lookup table with N_CH registered read
// channels, each carrying its own stepping cursor.
// Build option: define BIT_ADDR_LUT_WRITE_EN to get a writable table with a
// write-through bypass; without it the wr_* ports are ignored and the table
// is the constant default contents (a ROM).
module bit_addr_lut #(
  parameter int KEY_W  = bit_addr_lut_pkg::KEY_W,
  parameter int DEPTH  = bit_addr_lut_pkg::DEPTH,
  parameter int ADDR_W = bit_addr_lut_pkg::ADDR_W,
  parameter int N_CH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CH-1:0]              rd_req,
  input  logic [N_CH-1:0][KEY_W-1:0]   rd_key,
  input  logic [N_CH-1:0]              rd_step,
  output logic [N_CH-1:0][ADDR_W-1:0]  rd_addr,
  output logic [N_CH-1:0]              rd_valid,
  output logic [N_CH-1:0]              rd_err,
  output logic [N_CH-1:0]              rd_wrap,
  input  logic                         wr_en,
  input  logic [KEY_W-1:0]             wr_key,
  input  logic [ADDR_W-1:0]            wr_addr
);
  import bit_addr_lut_pkg::*;

  // The read mux spans the whole key space so any key indexes it directly;
  // slots at or above DEPTH are tied to 0 and flagged as errors separately.
  localparam int KEY_SPAN = 2 ** KEY_W;

  logic [ADDR_W-1:0] table_flat [KEY_SPAN];

`ifndef BIT_ADDR_LUT_WRITE_EN
  // Write port is present for pin compatibility only in the ROM build.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_key, wr_addr};
`endif

  genvar gi;

  // Table storage: one register per live entry, or a constant in the ROM build.
  for (gi = 0; gi < KEY_SPAN; gi++) begin : g_entry
    if (gi < DEPTH) begin : g_live
`ifdef BIT_ADDR_LUT_WRITE_EN
      logic [ADDR_W-1:0] entry_reg;
      logic              wr_hit;

      // Keys at or above DEPTH match no live entry, so such writes vanish.
      assign wr_hit = wr_en && (wr_key == KEY_W'(gi));

      // Entry register: reload default on reset, take wr_addr when addressed.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_reg <= ADDR_W'(default_entry(gi));
        end else if (wr_hit) begin
          entry_reg <= wr_addr;
        end
      end

      assign table_flat[gi] = entry_reg;
`else
      assign table_flat[gi] = ADDR_W'(default_entry(gi));
`endif
    end else begin : g_pad
      assign table_flat[gi] = '0;
    end
  end

  // Read channels: range check and lookup here, state and pulses in the cursor.
  for (gi = 0; gi < N_CH; gi++) begin : g_ch
    logic              key_err;
    logic [ADDR_W-1:0] lookup_val;

    assign key_err = 32'(rd_key[gi]) >= 32'(DEPTH);

`ifdef BIT_ADDR_LUT_WRITE_EN
    logic bypass_hit;

    // A same-cycle write to the requested key is forwarded so the request
    // sees the new value rather than the one about to be overwritten.
    assign bypass_hit = wr_en && (wr_key == rd_key[gi]) && !key_err;
    assign lookup_val = bypass_hit ? wr_addr : table_flat[rd_key[gi]];
`else
    assign lookup_val = table_flat[rd_key[gi]];
`endif

    bit_addr_cursor #(
      .ADDR_W (ADDR_W)
    ) u_cursor (
      .clk        (clk),
      .reset      (reset),
      .req        (rd_req[gi]),
      .step       (rd_step[gi]),
      .key_err    (key_err),
      .lookup_val (lookup_val),
      .addr       (rd_addr[gi]),
      .valid      (rd_valid[gi]),
      .err        (rd_err[gi]),
      .wrap       (rd_wrap[gi])
    );
  end

endmodule

// File: tb/tb_bit_addr_lut.sv
// Scoreboard bench for bit_addr_lut. Two instances share one stimulus stream:
// dut_a with the full 16-entry table and dut_b with DEPTH=12, so out-of-range
// keys are exercised. Expected responses are pushed per stream when stimulus
// is issued; a monitor pops them whenever a channel presents rd_valid.
module tb_bit_addr_lut;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       rd_req;
  logic [1:0][3:0]  rd_key;
  logic [1:0]       rd_step;
  logic             wr_en;
  logic [3:0]       wr_key;
  logic [8:0]       wr_addr;

  logic [1:0][8:0]  addr_a, addr_b;
  logic [1:0]       valid_a, err_a, wrap_a;
  logic [1:0]       valid_b, err_b, wrap_b;

  // Stream s = instance*2 + channel.
  logic [3:0][8:0]  a_all;
  logic [3:0]       v_all, e_all, w_all;
  assign a_all = {addr_b, addr_a};
  assign v_all = {valid_b, valid_a};
  assign e_all = {err_b, err_a};
  assign w_all = {wrap_b, wrap_a};

  always #5 clk = ~clk;

  bit_addr_lut #(.KEY_W(4), .DEPTH(16), .ADDR_W(9), .N_CH(2)) dut_a (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_key(rd_key), .rd_step(rd_step),
    .rd_addr(addr_a), .rd_valid(valid_a), .rd_err(err_a), .rd_wrap(wrap_a),
    .wr_en(wr_en), .wr_key(wr_key), .wr_addr(wr_addr)
  );

  bit_addr_lut #(.KEY_W(4), .DEPTH(12), .ADDR_W(9), .N_CH(2)) dut_b (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_key(rd_key), .rd_step(rd_step),
    .rd_addr(addr_b), .rd_valid(valid_b), .rd_err(err_b), .rd_wrap(wrap_b),
    .wr_en(wr_en), .wr_key(wr_key), .wr_addr(wr_addr)
  );

`ifdef BIT_ADDR_LUT_WRITE_EN
  localparam bit WR_ON = 1'b1;
`else
  localparam bit WR_ON = 1'b0;
`endif

  // Reference model: table contents, channel loaded flags and cursors.
  int unsigned defaults [16] = '{0, 1, 5, 8, 240, 247, 248, 251,
                                 253, 254, 255, 256, 264, 272, 280, 0};
  int unsigned tbl [2][16];
  bit          loaded [2][2];
  int unsigned cur [2][2];

  typedef struct {
    int unsigned addr;
    bit          err;
    bit          wrap;
  } exp_t;

  exp_t        exp_q [4][$];
  int unsigned hold [4];
  int          errors = 0;
  int          checks = 0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) tbl[k][i] = (i < depth_of(k)) ? defaults[i] : 0;
      for (int c = 0; c < 2; c++) begin
        loaded[k][c] = 1'b0;
        cur[k][c]    = 0;
        exp_q[k*2+c].delete();
      end
    end
  endtask

  // One clock of stimulus; expected responses for the coming edge are queued.
  task automatic cycle(input bit [1:0] req, input int k0, input int k1, input bit [1:0] step,
                       input bit wen, input int wk, input int unsigned wa);
    exp_t e;
    int   key;
    @(negedge clk);
    rd_req    = req;
    rd_key[0] = 4'(k0);
    rd_key[1] = 4'(k1);
    rd_step   = step;
    wr_en     = wen;
    wr_key    = 4'(wk);
    wr_addr   = 9'(wa);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        key = (c == 0) ? k0 : k1;
        if (req[c]) begin
          e.err  = (key >= depth_of(k));
          e.wrap = 1'b0;
          if (e.err)                              e.addr = 0;
          else if (WR_ON && wen && wk == key)     e.addr = wa % 512;
          else                                    e.addr = tbl[k][key];
          cur[k][c]    = e.addr;
          loaded[k][c] = 1'b1;
          exp_q[k*2+c].push_back(e);
        end else if (step[c] && loaded[k][c]) begin
          cur[k][c] = (cur[k][c] + 1) % 512;
          e.addr = cur[k][c];
          e.err  = 1'b0;
          e.wrap = (cur[k][c] == 0);
          exp_q[k*2+c].push_back(e);
        end
      end
      if (WR_ON && wen && wk < depth_of(k)) tbl[k][wk] = wa % 512;
    end
  endtask

  task automatic idle();
    cycle(2'b00, 0, 0, 2'b00, 1'b0, 0, 0);
  endtask

  // Reset asserted in mid-cycle: outputs must clear without waiting for clk.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("async_reset_addr s%0d", s), 32'(a_all[s]), 0);
      check($sformatf("async_reset_valid s%0d", s), 32'(v_all[s]), 0);
    end
    rd_req = '0; rd_step = '0; wr_en = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pop and compare on rd_valid, otherwise require quiet, held outputs.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        for (int s = 0; s < 4; s++) hold[s] = 0;
      end else begin
        for (int s = 0; s < 4; s++) begin
          if (v_all[s]) begin
            if (exp_q[s].size() == 0) begin
              check($sformatf("unexpected_valid s%0d", s), 32'(v_all[s]), 0);
            end else begin
              x = exp_q[s].pop_front();
              $display("s%0d txn addr=%0d err=%0d wrap=%0d (exp %0d/%0d/%0d)",
                       s, a_all[s], e_all[s], w_all[s], x.addr, x.err, x.wrap);
              check($sformatf("addr s%0d", s), 32'(a_all[s]), x.addr);
              check($sformatf("err s%0d", s), 32'(e_all[s]), 32'(x.err));
              check($sformatf("wrap s%0d", s), 32'(w_all[s]), 32'(x.wrap));
              hold[s] = x.addr;
            end
          end else begin
            check($sformatf("quiet_err s%0d", s), 32'(e_all[s]), 0);
            check($sformatf("quiet_wrap s%0d", s), 32'(w_all[s]), 0);
            check($sformatf("hold_addr s%0d", s), 32'(a_all[s]), hold[s]);
          end
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    rd_req  = '0;
    rd_key  = '0;
    rd_step = '0;
    wr_en   = 1'b0;
    wr_key  = '0;
    wr_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("reset_addr s%0d", s), 32'(a_all[s]), 0);
      check($sformatf("reset_valid s%0d", s), 32'(v_all[s]), 0);
      check($sformatf("reset_err s%0d", s), 32'(e_all[s]), 0);
      check($sformatf("reset_wrap s%0d", s), 32'(w_all[s]), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Plain lookup.
    cycle(2'b01, 11, 0, 2'b00, 1'b0, 0, 0);
    // Lookup then three back-to-back steps.
    cycle(2'b01, 4, 0, 2'b00, 1'b0, 0, 0);
    repeat (3) cycle(2'b00, 0, 0, 2'b01, 1'b0, 0, 0);
    // Load, rewrite entry 10 to the top address, reload, step across the wrap.
    cycle(2'b10, 0, 10, 2'b00, 1'b0, 0, 0);
    cycle(2'b00, 0, 0, 2'b00, 1'b1, 10, 511);
    cycle(2'b10, 0, 10, 2'b00, 1'b0, 0, 0);
    cycle(2'b00, 0, 0, 2'b10, 1'b0, 0, 0);
    // Write and two requests to the same key in one cycle.
    cycle(2'b11, 2, 2, 2'b00, 1'b1, 2, 100);
    // Step straight after reset is ignored; request beats step.
    reset_mid();
    cycle(2'b00, 0, 0, 2'b01, 1'b0, 0, 0);
    cycle(2'b10, 0, 14, 2'b10, 1'b0, 0, 0);
    // Out-of-range key on the 12-entry instance.
    cycle(2'b11, 13, 13, 2'b00, 1'b0, 0, 0);
    // Write entry 0, read it, reset mid-stream, read the restored default.
    cycle(2'b00, 0, 0, 2'b00, 1'b1, 0, 77);
    cycle(2'b11, 0, 0, 2'b00, 1'b0, 0, 0);
    reset_mid();
    cycle(2'b11, 0, 0, 2'b00, 1'b0, 0, 0);
    // Long step run from 280 through the 511 -> 0 wrap.
    cycle(2'b01, 14, 0, 2'b00, 1'b0, 0, 0);
    repeat (232) cycle(2'b00, 0, 0, 2'b01, 1'b0, 0, 0);
    // Random traffic with one mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) reset_mid();
      cycle(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 15)), $urandom_range(0, 511));
    end
    idle();
    idle();
    @(posedge clk);
    #2;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("drain s%0d", s), 32'(exp_q[s].size()), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
